// File: rtl/hue_calc_pipe.sv
// hue_calc_pipe: fully pipelined RGB -> hue converter with ready/valid flow control.
//
// Ports
//   i_clk, i_rstn          clock (rising edge), asynchronous active-low reset
//   i_r, i_g, i_b [CW]     unsigned colour channels
//   i_user [UW]            sideband carried alongside each pixel
//   i_valid / o_ready      input handshake; o_ready = !o_valid | i_ready
//   o_hue [9+FRAC]         hue in degrees * 2^FRAC, range [0, 360*2^FRAC - 1]
//   o_delta, o_max [CW]    chroma (max - min) and max channel
//   o_gray                 delta == 0 (hue forced to 0)
//   o_user [UW]            sideband of the output pixel
//   o_valid / i_ready      output handshake
//
// Pipeline: stage 0 (sector select), QW = 6+FRAC restoring-divider stages,
// then one output stage, giving QW+2 cycles of latency. A single global
// enable stalls every stage (valids included) under backpressure.
module hue_calc_pipe #(
    parameter int CW   = 8,
    parameter int FRAC = 0,
    parameter int UW   = 1
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic [CW-1:0]   i_r,
    input  logic [CW-1:0]   i_g,
    input  logic [CW-1:0]   i_b,
    input  logic [UW-1:0]   i_user,
    input  logic            i_valid,
    output logic            o_ready,
    output logic [8+FRAC:0] o_hue,
    output logic [CW-1:0]   o_delta,
    output logic [CW-1:0]   o_max,
    output logic            o_gray,
    output logic [UW-1:0]   o_user,
    output logic            o_valid,
    input  logic            i_ready
);

    localparam int QW     = 6 + FRAC;
    localparam int DW     = CW + 6 + FRAC;
    localparam int HW     = 9 + FRAC;
    localparam int SW     = 11 + FRAC;
    localparam int QSCALE = 60 * (2 ** FRAC);

    // One restoring-division step: trial-subtract delta aligned to bit k.
    function automatic logic div_bit(input logic [DW-1:0] rem, input logic [CW-1:0] dlt,
                                     input int k);
        logic [DW-1:0] dsh;
        dsh = DW'(dlt) << k;
        return rem >= dsh;
    endfunction

    function automatic logic [DW-1:0] div_rem(input logic [DW-1:0] rem,
                                              input logic [CW-1:0] dlt, input int k);
        logic [DW-1:0] dsh;
        dsh = DW'(dlt) << k;
        return (rem >= dsh) ? rem - dsh : rem;
    endfunction

    // Combine sector base and signed quotient, then wrap into [0, 360*2^FRAC).
    function automatic logic [HW-1:0] hue_wrap(input logic [1:0] sec, input logic sgn,
                                               input logic [QW-1:0] q);
        logic signed [SW-1:0] b, qs, h, full;
        full = SW'(360 * (2 ** FRAC));
        case (sec)
            2'd1:    b = SW'(120 * (2 ** FRAC));
            2'd2:    b = SW'(240 * (2 ** FRAC));
            default: b = '0;
        endcase
        qs = SW'(q);
        h  = sgn ? b - qs : b + qs;
        if (h < 0) h = h + full;
        if (h == full) h = '0;
        return HW'(h);
    endfunction

    logic en;
    assign en      = !o_valid || i_ready;
    assign o_ready = en;

    // Stage 0 combinational: max/min/delta and sector with R > G > B tie priority
    logic        [CW-1:0] mx_d, mn_d, dlt_d, absn_d;
    logic signed [CW:0]   num_d;
    logic        [1:0]    sec_d;
    logic                 sgn_d;
    logic        [DW-1:0] rem_d;

    always_comb begin
        mx_d  = i_b;
        sec_d = 2'd2;
        num_d = $signed({1'b0, i_r}) - $signed({1'b0, i_g});
        if (i_r >= i_g && i_r >= i_b) begin
            mx_d  = i_r;
            sec_d = 2'd0;
            num_d = $signed({1'b0, i_g}) - $signed({1'b0, i_b});
        end else if (i_g >= i_b) begin
            mx_d  = i_g;
            sec_d = 2'd1;
            num_d = $signed({1'b0, i_b}) - $signed({1'b0, i_r});
        end
        mn_d = i_r;
        if (i_g < mn_d) mn_d = i_g;
        if (i_b < mn_d) mn_d = i_b;
        dlt_d  = mx_d - mn_d;
        sgn_d  = num_d[CW];
        absn_d = sgn_d ? CW'(-num_d) : CW'(num_d);
        rem_d  = DW'(absn_d) * DW'(QSCALE);
    end

    // Stage data registers (index = stage number); no reset, qualified by vld_q
    logic [DW-1:0] rem_q [0:QW-1];
    logic [QW-1:0] quo_q [0:QW];
    logic [CW-1:0] dlt_q [0:QW];
    logic [CW-1:0] mx_q  [0:QW];
    logic [1:0]    sec_q [0:QW];
    logic          sgn_q [0:QW];
    logic [UW-1:0] usr_q [0:QW];
    logic [QW:0]   vld_q;

    always_ff @(posedge i_clk) begin
        if (en) begin
            rem_q[0] <= rem_d;
            quo_q[0] <= '0;
            dlt_q[0] <= dlt_d;
            mx_q[0]  <= mx_d;
            sec_q[0] <= sec_d;
            sgn_q[0] <= sgn_d;
            usr_q[0] <= i_user;
            // Stages 1..QW: quotient bits shift in MSB first
            for (int s = 1; s <= QW; s++) begin
                quo_q[s] <= {quo_q[s-1][QW-2:0], div_bit(rem_q[s-1], dlt_q[s-1], QW - s)};
                dlt_q[s] <= dlt_q[s-1];
                mx_q[s]  <= mx_q[s-1];
                sec_q[s] <= sec_q[s-1];
                sgn_q[s] <= sgn_q[s-1];
                usr_q[s] <= usr_q[s-1];
            end
            for (int s = 1; s < QW; s++) begin
                rem_q[s] <= div_rem(rem_q[s-1], dlt_q[s-1], QW - s);
            end
        end
    end

    // Output stage: valids and output registers reset so outputs read 0
    logic [HW-1:0] hue_q;
    logic [CW-1:0] odlt_q, omx_q;
    logic          gray_q, ovld_q;
    logic [UW-1:0] ousr_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            vld_q  <= '0;
            ovld_q <= 1'b0;
            hue_q  <= '0;
            odlt_q <= '0;
            omx_q  <= '0;
            gray_q <= 1'b0;
            ousr_q <= '0;
        end else if (en) begin
            vld_q  <= {vld_q[QW-1:0], i_valid};
            ovld_q <= vld_q[QW];
            // Data only loads on a valid pixel, so bubbles keep outputs at last/zero value
            if (vld_q[QW]) begin
                hue_q  <= (dlt_q[QW] == '0) ? '0 : hue_wrap(sec_q[QW], sgn_q[QW], quo_q[QW]);
                odlt_q <= dlt_q[QW];
                omx_q  <= mx_q[QW];
                gray_q <= (dlt_q[QW] == '0);
                ousr_q <= usr_q[QW];
            end
        end
    end

    assign o_hue   = hue_q;
    assign o_delta = odlt_q;
    assign o_max   = omx_q;
    assign o_gray  = gray_q;
    assign o_user  = ousr_q;
    assign o_valid = ovld_q;

endmodule

// File: tb/tb_hue_calc_pipe.sv
module tb_hue_calc_pipe;

    localparam int LAT0 = 8;
    localparam int LAT4 = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] r, g, b, usr;
    logic       vin, rdy_in;

    logic       rdy0, gr0, ov0;
    logic [8:0] hue0;
    logic [7:0] dl0, mx0, us0;

    logic        vin4, rdy4, gr4, ov4;
    logic [12:0] hue4;
    logic [7:0]  dl4, mx4, us4;

    assign vin4 = vin && rdy0;

    hue_calc_pipe #(.CW(8), .FRAC(0), .UW(8)) u_dut0 (
        .i_clk(clk), .i_rstn(rst_n), .i_r(r), .i_g(g), .i_b(b), .i_user(usr),
        .i_valid(vin), .o_ready(rdy0), .o_hue(hue0), .o_delta(dl0), .o_max(mx0),
        .o_gray(gr0), .o_user(us0), .o_valid(ov0), .i_ready(rdy_in));

    hue_calc_pipe #(.CW(8), .FRAC(4), .UW(8)) u_dut4 (
        .i_clk(clk), .i_rstn(rst_n), .i_r(r), .i_g(g), .i_b(b), .i_user(usr),
        .i_valid(vin4), .o_ready(rdy4), .o_hue(hue4), .o_delta(dl4), .o_max(mx4),
        .o_gray(gr4), .o_user(us4), .o_valid(ov4), .i_ready(1'b1));

    typedef struct {
        logic [12:0] hue;
        logic [7:0]  dl;
        logic [7:0]  mx;
        logic        gr;
        logic [7:0]  us;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t q0[$];
    exp_t q4[$];

    int n_tot = 0;
    int n_pass = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int bp_cnt = 0;
    bit lat_chk = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference: hue from the sector rules with plain integer arithmetic
    function automatic exp_t ref_px(input logic [7:0] rr, gg, bb, uu, input int frac);
        exp_t e;
        int ri, gi, bi, mxv, mnv, d, num, base, q, h, full;
        ri = rr; gi = gg; bi = bb;
        mxv = (ri > gi) ? ri : gi;  mxv = (bi > mxv) ? bi : mxv;
        mnv = (ri < gi) ? ri : gi;  mnv = (bi < mnv) ? bi : mnv;
        d = mxv - mnv;
        if (ri >= gi && ri >= bi) begin num = gi - bi; base = 0; end
        else if (gi >= bi)        begin num = bi - ri; base = 120; end
        else                      begin num = ri - gi; base = 240; end
        full = 360 * (1 << frac);
        h = 0;
        if (d != 0) begin
            q = (60 * ((num < 0) ? -num : num) * (1 << frac)) / d;
            h = base * (1 << frac) + ((num < 0) ? -q : q);
            if (h < 0) h += full;
            if (h == full) h = 0;
        end
        e.hue = 13'(h);
        e.dl  = 8'(d);
        e.mx  = 8'(mxv);
        e.gr  = (d == 0);
        e.us  = uu;
        e.cyc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    // Present a pixel until accepted, then push expectations for both DUTs
    task automatic send(input logic [7:0] rr, gg, bb, uu, input bit use_tab,
                        input int h0, input int h4);
        exp_t e0, e4;
        bit acc = 1'b0;
        e0 = ref_px(rr, gg, bb, uu, 0);
        e4 = ref_px(rr, gg, bb, uu, 4);
        if (use_tab) begin
            e0.hue = 13'(h0);
            e4.hue = 13'(h4);
        end
        for (int i = 0; i < 500 && !acc; i++) begin
            @(negedge clk);
            r = rr; g = gg; b = bb; usr = uu; vin = 1'b1;
            #1;
            if (rdy0) acc = 1'b1;
        end
        if (acc) begin
            e0.cyc = cyc; e0.lat = lat_chk;
            e4.cyc = cyc; e4.lat = 1'b1;
            q0.push_back(e0);
            q4.push_back(e4);
        end else begin
            chk("accept_timeout", 0, 1);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        vin = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (q0.size() + q4.size()) != 0; i++) @(negedge clk);
        chk("drain_left", q0.size() + q4.size(), 0);
    endtask

    task automatic rand_px(output logic [7:0] rr, gg, bb);
        int m;
        m = $urandom % 8;
        rr = 8'($urandom); gg = 8'($urandom); bb = 8'($urandom);
        if (m == 0) begin gg = rr; bb = rr; end
        else if (m == 1) gg = rr;
        else if (m == 2) bb = gg;
    endtask

    always @(negedge clk) begin
        case (rdy_mode)
            0: rdy_in = 1'b1;
            1: begin
                bp_cnt++;
                rdy_in = (bp_cnt >= 6 && bp_cnt <= 10) ? 1'b0 : (($urandom % 3) != 0);
            end
            default: rdy_in = 1'b0;
        endcase
    end

    // Monitor for the FRAC=0 instance: handshake, hold-while-stalled, scoreboard
    bit         stall0 = 1'b0;
    logic [8:0] hh0;
    logic [7:0] hd0, hm0, hu0;
    logic       hg0;

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n) begin
            chk("o_ready_eq", rdy0, !ov0 || rdy_in);
            if (stall0) begin
                chk("hold_valid", ov0, 1);
                chk("hold_hue", hue0, hh0);
                chk("hold_delta", dl0, hd0);
                chk("hold_max", mx0, hm0);
                chk("hold_gray", gr0, hg0);
                chk("hold_user", us0, hu0);
            end
            if (ov0 && rdy_in) begin
                if (q0.size() == 0) chk("unexpected_out0", 1, 0);
                else begin
                    e = q0.pop_front();
                    chk("hue0", hue0, e.hue);
                    chk("delta0", dl0, e.dl);
                    chk("max0", mx0, e.mx);
                    chk("gray0", gr0, e.gr);
                    chk("user0", us0, e.us);
                    if (e.lat) chk("latency0", cyc - e.cyc, LAT0);
                end
            end
            stall0 = ov0 && !rdy_in;
            hh0 = hue0; hd0 = dl0; hm0 = mx0; hg0 = gr0; hu0 = us0;
        end else begin
            stall0 = 1'b0;
        end
    end

    // Monitor for the FRAC=4 instance (never backpressured)
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n) begin
            chk("o_ready4", rdy4, 1);
            if (ov4) begin
                chk("hue4_range", (hue4 <= 13'd5759), 1);
                if (q4.size() == 0) chk("unexpected_out4", 1, 0);
                else begin
                    e = q4.pop_front();
                    chk("hue4", hue4, e.hue);
                    chk("delta4", dl4, e.dl);
                    chk("max4", mx4, e.mx);
                    chk("gray4", gr4, e.gr);
                    chk("user4", us4, e.us);
                    if (e.lat) chk("latency4", cyc - e.cyc, LAT4);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct { logic [7:0] r, g, b; int h0, h4; } dir_t;
    dir_t dir[8];

    initial begin
        logic [7:0] rr, gg, bb;
        dir[0] = '{8'd255, 8'd0,   8'd0,   0,   0};
        dir[1] = '{8'd0,   8'd255, 8'd0,   120, 1920};
        dir[2] = '{8'd0,   8'd0,   8'd255, 240, 3840};
        dir[3] = '{8'd255, 8'd0,   8'd128, 330, 5279};
        dir[4] = '{8'd0,   8'd128, 8'd255, 210, 3359};
        dir[5] = '{8'd255, 8'd255, 8'd0,   60,  960};
        dir[6] = '{8'd255, 8'd0,   8'd1,   0,   5757};
        dir[7] = '{8'd100, 8'd100, 8'd100, 0,   0};

        rst_n = 1'b0; vin = 1'b0; r = '0; g = '0; b = '0; usr = '0; rdy_in = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid0", ov0, 0);
        chk("rst_hue0", hue0, 0);
        chk("rst_delta0", dl0, 0);
        chk("rst_max0", mx0, 0);
        chk("rst_gray0", gr0, 0);
        chk("rst_user0", us0, 0);
        chk("rst_ready0", rdy0, 1);
        chk("rst_valid4", ov4, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed pixels back-to-back, no backpressure
        lat_chk = 1'b1;
        for (int i = 0; i < 8; i++) send(dir[i].r, dir[i].g, dir[i].b, 8'(i), 1'b1, dir[i].h0, dir[i].h4);
        idle();
        drain();

        // Backpressure stream with user counter, then a longer random sweep
        lat_chk = 1'b0;
        bp_cnt = 0;
        rdy_mode = 1;
        for (int i = 0; i < 170; i++) begin
            rand_px(rr, gg, bb);
            send(rr, gg, bb, 8'(i), 1'b0, 0, 0);
            if (($urandom % 5) == 0) idle();
        end
        idle();
        drain();
        rdy_mode = 0;
        repeat (2) @(negedge clk);

        // Reset with pixels in flight and the output stalled
        rdy_mode = 2;
        for (int i = 0; i < 7; i++) begin
            rand_px(rr, gg, bb);
            send(rr, gg, bb, 8'(8'hA0 + i), 1'b0, 0, 0);
        end
        idle();
        for (int i = 0; i < 30 && !ov0; i++) @(negedge clk);
        #1;
        chk("fill_valid", ov0, 1);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid0", ov0, 0);
        chk("arst_hue0", hue0, 0);
        chk("arst_delta0", dl0, 0);
        chk("arst_max0", mx0, 0);
        chk("arst_gray0", gr0, 0);
        chk("arst_user0", us0, 0);
        chk("arst_valid4", ov4, 0);
        chk("arst_hue4", hue4, 0);
        q0.delete();
        q4.delete();
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("ready_after_rst", rdy0, 1);
        rdy_mode = 0;
        lat_chk = 1'b1;
        send(8'd255, 8'd0, 8'd128, 8'h5A, 1'b1, 330, 5279);
        idle();
        drain();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
